// File: rtl/riscv_fetch_pkg.sv
// Shared constants and types for the prefetching fetch stage.
package riscv_fetch_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR        = 32'h00000013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [DEFAULT_ADDRESS_WIDTH-1:0] pc;
        logic [DEFAULT_DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; caller must not push when full (unless popping) or pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [WIDTH-1:0] head_data
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign head_data = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage with credit-limited instruction prefetch, in-order response buffering and
// redirect flush that drops responses to requests issued before the redirect.
module fetch_prefetch
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    output logic                     instr_valid_f,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4,
    output logic [DATA_WIDTH-1:0]    instr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    // Dropped plus live requests can reach twice the depth right after a redirect.
    localparam int unsigned CNT_W = PTR_W + 2;
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [ADDRESS_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]         in_flight_q, in_flight_d;
    logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;

    logic             fifo_full, fifo_empty;
    logic [PTR_W:0]   fifo_count;
    entry_t           push_entry, head_entry;
    logic             req_hs, rsp_ok, push, pop;
    logic [CNT_W-1:0] credits_used;
    logic [ADDRESS_WIDTH-1:0] target_aligned;

    assign target_aligned = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};

    assign credits_used   = in_flight_q - drop_cnt_q + CNT_W'(fifo_count);
    assign imem_req_valid = !pc_src_e && (credits_used < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = req_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are protocol violations and ignored.
    assign rsp_ok = imem_rsp_valid && (in_flight_q != '0);
    assign push   = !pc_src_e && rsp_ok && (drop_cnt_q == '0);
    assign pop    = !pc_src_e && !fifo_empty && !stall_f;

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        req_pc_d    = req_pc_q;
        rsp_pc_d    = rsp_pc_q;
        drop_cnt_d  = drop_cnt_q;
        in_flight_d = in_flight_q + CNT_W'(req_hs) - CNT_W'(rsp_ok);
        if (pc_src_e) begin
            req_pc_d   = target_aligned;
            rsp_pc_d   = target_aligned;
            drop_cnt_d = in_flight_q - CNT_W'(rsp_ok);
        end else begin
            if (req_hs) req_pc_d = req_pc_q + PC_STEP;
            if (rsp_ok) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
                else                  rsp_pc_d   = rsp_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pc_q    <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            req_pc_q    <= req_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (ADDRESS_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (pc_src_e),
        .push_data (push_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (head_entry)
    );

    assign instr_valid_f = !fifo_empty;
    assign pc            = fifo_empty ? '0 : head_entry.pc;
    assign pc_plus4      = fifo_empty ? '0 : head_entry.pc + PC_STEP;
    assign instr         = fifo_empty ? DATA_WIDTH'(NOP_INSTR) : head_entry.instr;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a behavioural fixed-latency instruction memory.
module tb_fetch_prefetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rst2_n, stall_f, pc_src_e, imem_req_ready, imem_rsp_valid;
    logic [AW-1:0] pc_target_e;
    logic [DW-1:0] imem_rsp_data;

    logic          rv_a, iv_a, rv_b, iv_b;
    logic [AW-1:0] addr_a, pc_a, pc4_a, addr_b, pc_b, pc4_b;
    logic [DW-1:0] instr_a, instr_b;

    fetch_prefetch u_dut_a (
        .clk (clk), .rst_n (rst_n), .stall_f (stall_f), .pc_src_e (pc_src_e),
        .pc_target_e (pc_target_e), .imem_req_valid (rv_a), .imem_req_ready (imem_req_ready),
        .imem_req_addr (addr_a), .imem_rsp_valid (imem_rsp_valid), .imem_rsp_data (imem_rsp_data),
        .instr_valid_f (iv_a), .pc (pc_a), .pc_plus4 (pc4_a), .instr (instr_a)
    );

    fetch_prefetch #(.RESET_PC (32'hFFFFFFF8)) u_dut_b (
        .clk (clk), .rst_n (rst2_n), .stall_f (stall_f), .pc_src_e (pc_src_e),
        .pc_target_e (pc_target_e), .imem_req_valid (rv_b), .imem_req_ready (imem_req_ready),
        .imem_req_addr (addr_b), .imem_rsp_valid (imem_rsp_valid), .imem_rsp_data (imem_rsp_data),
        .instr_valid_f (iv_b), .pc (pc_b), .pc_plus4 (pc4_b), .instr (instr_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 1;
    int pops   = 0;
    bit sel_b  = 1'b0;
    logic [AW-1:0] exp_pc;

    typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
    mreq_t mq[$];

    logic          cur_rv, cur_iv;
    logic [AW-1:0] cur_addr, cur_pc, cur_pc4;
    logic [DW-1:0] cur_instr;

    typedef struct {
        logic          exp_rv;
        logic [AW-1:0] exp_addr;
        logic          exp_iv;
        logic [AW-1:0] exp_pc;
        logic [DW-1:0] exp_instr;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void sample();
        if (sel_b) begin
            cur_rv = rv_b; cur_addr = addr_b; cur_iv = iv_b;
            cur_pc = pc_b; cur_pc4 = pc4_b; cur_instr = instr_b;
        end else begin
            cur_rv = rv_a; cur_addr = addr_a; cur_iv = iv_a;
            cur_pc = pc_a; cur_pc4 = pc4_a; cur_instr = instr_a;
        end
    endfunction

    // One clock cycle: drive inputs and the memory response, then sample and log the handshake.
    task automatic step(input bit ready, input bit stall, input bit redir, input logic [AW-1:0] tgt);
        @(negedge clk);
        imem_req_ready = ready;
        stall_f        = stall;
        pc_src_e       = redir;
        pc_target_e    = tgt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        sample();
        if (cur_rv && ready) mq.push_back('{addr: cur_addr, due: cyc + lat});
        cyc++;
    endtask

    task automatic track(input bit stall);
        if (cur_iv && !stall) begin
            check("order_pc", cur_pc, exp_pc);
            check("order_instr", cur_instr, mem_data(exp_pc));
            exp_pc += 4;
            pops++;
        end
    endtask

    task automatic do_reset(input bit b, input logic [AW-1:0] rpc);
        @(negedge clk);
        rst_n = 1'b0; rst2_n = 1'b0;
        stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        mq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        sel_b = b;
        if (b) rst2_n = 1'b1; else rst_n = 1'b1;
        cyc = 0;
        sample();
        check("rst_iv", cur_iv, 0);
        check("rst_pc", cur_pc, 0);
        check("rst_pc4", cur_pc4, 0);
        check("rst_instr", cur_instr, NOP);
        check("rst_addr", cur_addr, rpc);
        check("rst_rv", cur_rv, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int hs_cnt;
        logic [AW-1:0] prev_addr;
        bit prev_wait;

        tbl[0] = '{1'b1, 32'h00, 1'b0, 32'h0, NOP};
        tbl[1] = '{1'b1, 32'h04, 1'b0, 32'h0, NOP};
        tbl[2] = '{1'b1, 32'h08, 1'b1, 32'h0, 32'hA5A50000};
        tbl[3] = '{1'b1, 32'h0C, 1'b1, 32'h4, 32'hA5A50004};
        tbl[4] = '{1'b1, 32'h10, 1'b1, 32'h8, 32'hA5A50008};
        tbl[5] = '{1'b1, 32'h14, 1'b1, 32'hC, 32'hA5A5000C};

        // Streaming with 1-cycle memory, ready always high.
        do_reset(1'b0, 32'h0);
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            check("vec_req_valid", cur_rv, tbl[i].exp_rv);
            check("vec_req_addr", cur_addr, tbl[i].exp_addr);
            check("vec_instr_valid", cur_iv, tbl[i].exp_iv);
            check("vec_pc", cur_pc, tbl[i].exp_pc);
            check("vec_pc_plus4", cur_pc4, tbl[i].exp_iv ? tbl[i].exp_pc + 32'd4 : 32'd0);
            check("vec_instr", cur_instr, tbl[i].exp_instr);
        end

        // Stall holds the head; prefetch stops once credits run out.
        hs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (cur_rv) hs_cnt++;
            check("stall_pc", cur_pc, 32'h10);
            check("stall_instr", cur_instr, mem_data(32'h10));
        end
        check("stall_hs_bound", (hs_cnt <= 4), 1);
        check("stall_req_dropped", cur_rv, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            check("release_valid", cur_iv, 1);
            check("release_pc", cur_pc, 32'h10 + 32'(4 * i));
        end
        exp_pc = 32'h30;

        // Latency 3 with ready toggling: address held while stalled by the memory.
        lat = 3;
        pops = 0;
        prev_wait = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 40; i++) begin
            step(1'(cyc % 2), 1'b0, 1'b0, '0);
            if (prev_wait) check("hold_addr", cur_addr, prev_addr);
            prev_wait = cur_rv && !imem_req_ready;
            prev_addr = cur_addr;
            track(1'b0);
        end
        check("lat3_progress", (pops >= 8), 1);

        // Drain, then build exactly three outstanding requests and redirect.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            track(1'b0);
        end
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mq.size() == 3) begin found = 1'b1; break; end
            step(1'b1, 1'b0, 1'b0, '0);
            track(1'b0);
        end
        check("redir_three_in_flight", found, 1);
        step(1'b1, 1'b0, 1'b1, 32'h000000FF);
        check("redir_req_blocked", cur_rv, 0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("redir_iv_low", cur_iv, 0);
        check("redir_req_valid", cur_rv, 1);
        check("redir_first_addr", cur_addr, 32'hFC);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cur_iv) begin found = 1'b1; break; end
            step(1'b1, 1'b0, 1'b0, '0);
        end
        check("redir_wait", found, 1);
        check("redir_pc", cur_pc, 32'hFC);
        check("redir_pc4", cur_pc4, 32'h100);
        check("redir_instr", cur_instr, mem_data(32'hFC));
        exp_pc = 32'h100;

        // Redirect in a cycle carrying both a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (iv_a && mq.size() > 0 && mq[0].due <= cyc) begin found = 1'b1; break; end
            step(1'b1, 1'b0, 1'b0, '0);
            track(1'b0);
        end
        check("rsp_redir_found", found, 1);
        step(1'b1, 1'b0, 1'b1, 32'h00000400);
        check("rsp_redir_head_shown", cur_iv, 1);
        step(1'b1, 1'b0, 1'b0, '0);
        check("rsp_redir_iv_low", cur_iv, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cur_iv) begin found = 1'b1; break; end
            step(1'b1, 1'b0, 1'b0, '0);
        end
        check("rsp_redir_wait", found, 1);
        check("rsp_redir_pc", cur_pc, 32'h400);
        check("rsp_redir_instr", cur_instr, mem_data(32'h400));

        // Back-to-back redirects: only the last target is fetched.
        step(1'b1, 1'b0, 1'b1, 32'h00000500);
        step(1'b1, 1'b0, 1'b1, 32'h00000600);
        step(1'b1, 1'b0, 1'b0, '0);
        check("b2b_addr", cur_addr, 32'h600);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cur_iv) begin found = 1'b1; break; end
            step(1'b1, 1'b0, 1'b0, '0);
        end
        check("b2b_wait", found, 1);
        check("b2b_pc", cur_pc, 32'h600);

        // Reset PC near the top of the address space: wrap, then mid-stream reset.
        do_reset(1'b1, 32'hFFFFFFF8);
        lat = 1;
        step(1'b1, 1'b0, 1'b0, '0);
        check("wrap_addr0", cur_addr, 32'hFFFFFFF8);
        step(1'b1, 1'b0, 1'b0, '0);
        check("wrap_addr1", cur_addr, 32'hFFFFFFFC);
        step(1'b1, 1'b0, 1'b0, '0);
        check("wrap_addr2", cur_addr, 32'h00000000);
        check("wrap_pc0", cur_pc, 32'hFFFFFFF8);
        step(1'b1, 1'b0, 1'b0, '0);
        check("wrap_pc1", cur_pc, 32'hFFFFFFFC);
        check("wrap_pc4", cur_pc4, 32'h00000000);
        @(negedge clk);
        rst2_n = 1'b0;
        imem_rsp_valid = 1'b0;
        mq.delete();
        @(posedge clk);
        #1;
        sample();
        check("midrst_iv", cur_iv, 0);
        check("midrst_pc", cur_pc, 0);
        check("midrst_pc4", cur_pc4, 0);
        check("midrst_instr", cur_instr, NOP);
        check("midrst_addr", cur_addr, 32'hFFFFFFF8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised successor to the single-cycle fetch stage. It issues instruction-memory requests over a valid/ready handshake that tolerates variable latency, and buffers returned instructions with their PCs in a prefetch FIFO. It presents one instruction per cycle to decode, honouring stall_f. On an execute-stage redirect (pc_src_e) it flushes buffered and in-flight instructions.

Parameters:
DATA_WIDTH, 32, instruction width
ADDRESS_WIDTH, 32, PC/address width
FIFO_DEPTH, 4, prefetch entries; power of 2, >=2; also the maximum number of useful in-flight requests
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
stall_f  in  1  decode cannot accept; hold head entry
pc_src_e  in  1  redirect request from execute
pc_target_e  in  ADDRESS_WIDTH  redirect target
imem_req_valid  out  1  memory request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDRESS_WIDTH  request address
imem_rsp_valid  in  1  in-order response; no backpressure
imem_rsp_data  in  DATA_WIDTH  response instruction
instr_valid_f  out  1  head entry valid
pc  out  ADDRESS_WIDTH  PC of head instruction
pc_plus4  out  ADDRESS_WIDTH  pc + 4
instr  out  DATA_WIDTH  head instruction

Behaviour:
- Reset (rst_n=0 at a clk edge): req_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, in_flight=0, drop_cnt=0. The memory side is reset together; no pre-reset responses arrive.
- Outputs while instr_valid_f=0 (including reset): pc=0, pc_plus4=0, instr=NOP_INSTR (32'h00000013).
- Request side:
  - imem_req_valid = !pc_src_e && ((in_flight - drop_cnt) + fifo_count < FIFO_DEPTH).
  - imem_req_addr = req_pc.
  - On handshake (valid && ready), req_pc += 4, modulo 2^ADDRESS_WIDTH (wraps).
  - req_pc changes only on handshake or redirect. While valid && !ready, the address is stable.
- In-flight accounting: in_flight_next = in_flight + req_hs - imem_rsp_valid.
- Response side:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Else: push {rsp_pc, imem_rsp_data} into the FIFO, then rsp_pc += 4.
  - A response with in_flight=0 is a protocol violation and is ignored.
  - The credit rule guarantees the FIFO never overflows. Assert no push when full.
- Decode side:
  - instr_valid_f = !fifo_empty; pc, instr, pc_plus4 come from the head entry.
  - Pop when instr_valid_f && !stall_f.
  - Latency: a response accepted at edge N is visible at the head from cycle N+1 when the FIFO was empty. Minimum request-to-decode latency = memory latency + 1.
- stall_f: outputs hold, and prefetch continues until credits are exhausted.
- Redirect (pc_src_e=1), which wins over everything that cycle:
  - FIFO flushed; no push or pop.
  - req_pc = rsp_pc = pc_target_e.
  - drop_cnt_next = in_flight - imem_rsp_valid, i.e. all old requests still outstanding. A response arriving in the redirect cycle is discarded.
  - instr_valid_f=0 the following cycle.
  - The first target request issues the cycle after the redirect.
  - The team's scheme requires pc_target_e to be 4-byte aligned; bits [1:0] are ignored (forced to 0).
- Back-to-back redirects: each recomputes drop_cnt from the current in_flight; only the last target is fetched.
- Full/empty: pop and push in the same cycle on a full FIFO are allowed only if the credit rule permitted the response. Push and pop on an empty FIFO is not bypassed; the push lands and the head is valid the next cycle.

Decomposition:
- Package riscv_fetch_pkg:
  - NOP_INSTR constant.
  - Default RESET_PC.
  - fetch_entry_t typedef {pc, instr}, widths from the parameters.
- Sub-module sync_fifo:
  - Parametrised WIDTH and DEPTH.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Synchronous active-low reset.
- Request/credit/drop logic lives in fetch_prefetch.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A50000 -> requests at 0x0,0x4,0x8…; instr_valid_f rises 2 cycles after the first handshake with pc=0x0, pc_plus4=0x4, instr=32'hA5A50000.
- stall_f=1 for 10 cycles with FIFO_DEPTH=4 -> at most 4 handshakes beyond the entry held; imem_req_valid drops; pc/instr stable; on release, 4 consecutive instructions pop in order.
- Memory latency 3, ready toggling every other cycle -> imem_req_addr stable while valid && !ready; instructions arrive in PC order with no gaps or duplicates.
- Redirect to 0x000000FF with 3 requests in flight -> 3 responses discarded; next request at 0x000000FC; first valid output pc=0x000000FC.
- Redirect in the same cycle as imem_rsp_valid and a pop -> the response is discarded, nothing pops, instr_valid_f=0 next cycle.
- RESET_PC=32'hFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 (wrap); rst_n asserted mid-stream -> all outputs return to reset values at the next edge.
